mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 64 ++++++
 rtl/dmem_array.sv | 42 ++++
 rtl/mem_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared parameters for the core datapath: opcode and ALU
//               constants, data-memory FSM state encoding, Funct3
//               load/store codes, LATENCY range limits and the load
//               byte-lane formatting helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    // Base opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU operation select
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    // Data-memory access FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Funct3 load/store codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Legal LATENCY range (the WAIT counter is 4 bits wide)
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    // Select the addressed byte/halfword from a memory word and extend it.
    function automatic logic [31:0] load_format(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_LB:   load_format = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   load_format = {{16{sh[15]}}, sh[15:0]};
            F3_LBU:  load_format = {24'd0, sh[7:0]};
            F3_LHU:  load_format = {16'd0, sh[15:0]};
            default: load_format = word;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Single-port synchronous data RAM, 32-bit words with byte
//               enables. No reset: contents survive a core reset.
// Ports       : clk_i    - clock
//               addr_i   - word index (shared by read and write)
//               we_i     - write enable, be_i selects the byte lanes
//               wdata_i  - write data
//               re_i     - read enable; rdata_o holds between reads
//               rdata_o  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Multi-cycle data-memory responder. Accepts one load/store
//               in IDLE, waits LATENCY cycles, pulses Ready for one cycle
//               in RESP. Stores commit on the edge leaving RESP.
//               Optional macro SUBWORD_EN enables byte/halfword accesses
//               with sign/zero extension and misalignment faults.
// Ports       : clock, reset (sync, active-high)
//               MemRead, MemWrite, Address, WriteData, Funct3 - request
//               ReadData - load result, Ready - completion pulse
//               Stall - combinational pipeline freeze
//               Fault - misaligned/out-of-range/conflicting, with Ready
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2      // LATENCY_MIN..LATENCY_MAX
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [2:0]  Funct3,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Stall,
    output logic        Fault
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          is_read_q, is_write_q, fault_pend_q;
    logic          ready_q, fault_q, rd_zero_q;

    logic          w_req, w_idle, w_oor, w_misalign, w_req_fault;
    logic          w_cur_read, w_cur_fault;
    logic [AW-1:0] w_cur_idx, w_addr;
    logic          w_re, w_we;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_rdata;

    assign w_req  = MemRead | MemWrite;
    assign w_idle = (state_q == ST_IDLE);
    // Any address bit above the word index makes the access out of range.
    assign w_oor  = |(Address >> (AW + 2));

`ifdef SUBWORD_EN
    logic [2:0] f3_q, rd_f3_q, w_cur_f3;
    logic [1:0] off_q, rd_off_q, w_cur_off;

    always_comb begin
        w_misalign = 1'b0;
        case (Funct3[1:0])
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = Address[0];
            2'b10:   w_misalign = |Address[1:0];
            default: w_misalign = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (MemWrite && Funct3[2]) w_misalign = 1'b1;
    end

    assign w_cur_f3  = w_idle ? Funct3 : f3_q;
    assign w_cur_off = w_idle ? Address[1:0] : off_q;

    // Narrow stores replicate the data across lanes; enables pick the lane.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                w_be    = 4'b0001 << off_q;
                w_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << off_q;
                w_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign ReadData = rd_zero_q ? 32'd0 : load_format(w_rdata, rd_f3_q, rd_off_q);
`else
    logic w_unused;
    assign w_unused   = ^{Funct3, Address[1:0]};
    assign w_misalign = 1'b0;
    assign w_be       = 4'b1111;
    assign w_wdata    = wdata_q;
    assign ReadData   = rd_zero_q ? 32'd0 : w_rdata;
`endif

    assign w_req_fault = (MemRead & MemWrite) | w_oor | w_misalign;

    // In IDLE the access entering RESP (LATENCY=1) is still on the inputs;
    // otherwise it is the captured one.
    assign w_cur_read  = w_idle ? MemRead     : is_read_q;
    assign w_cur_fault = w_idle ? w_req_fault : fault_pend_q;
    assign w_cur_idx   = w_idle ? Address[AW+1:2] : idx_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_req) state_d = (LATENCY <= 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt_q <= 4'd1) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The RAM read register is loaded on the edge entering RESP and only on
    // good reads, so it holds the last load result; ReadData is that
    // register steered through byte-lane formatting captured on the same edge.
    assign w_re   = (state_d == ST_RESP) && w_cur_read && !w_cur_fault;
    assign w_we   = (state_q == ST_RESP) && is_write_q && !fault_pend_q && !reset;
    assign w_addr = (state_q == ST_RESP) ? idx_q : w_cur_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            is_read_q    <= 1'b0;
            is_write_q   <= 1'b0;
            fault_pend_q <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            rd_zero_q    <= 1'b1;
`ifdef SUBWORD_EN
            f3_q         <= F3_LW;
            off_q        <= 2'd0;
            rd_f3_q      <= F3_LW;
            rd_off_q     <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_RESP);
            fault_q <= (state_d == ST_RESP) && w_cur_fault;

            if (w_idle && w_req) begin
                idx_q        <= Address[AW+1:2];
                wdata_q      <= WriteData;
                is_read_q    <= MemRead;
                is_write_q   <= MemWrite & ~MemRead;
                fault_pend_q <= w_req_fault;
                cnt_q        <= WAIT_LOAD;
`ifdef SUBWORD_EN
                f3_q         <= Funct3;
                off_q        <= Address[1:0];
`endif
            end else if (state_q == ST_WAIT) begin
                cnt_q <= (cnt_q <= 4'd1) ? 4'd0 : cnt_q - 4'd1;
            end

            // Reads and faulting accesses update the visible load result.
            if ((state_d == ST_RESP) && (w_cur_read || w_cur_fault)) begin
                rd_zero_q <= w_cur_fault;
`ifdef SUBWORD_EN
                rd_f3_q   <= w_cur_f3;
                rd_off_q  <= w_cur_off;
`endif
            end
        end
    end

    assign Stall = (w_idle && w_req) || (state_q == ST_WAIT);
    assign Ready = ready_q;
    assign Fault = fault_q;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_dmem_array (
        .clk_i   (clock),
        .addr_i  (w_addr),
        .we_i    (w_we),
        .be_i    (w_be),
        .wdata_i (w_wdata),
        .re_i    (w_re),
        .rdata_o (w_rdata)
    );

endmodule
`default_nettype wire
